// File: rtl/uart_param.sv
// Single-clock UART with internal baud divider, configurable width/parity/stop bits.
// TX runs its own bit timer; RX uses a 2-flop synchroniser and 16x oversampling.
module uart_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int CLK_DIV   = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rdy,
  input  logic                 rdy_clr,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int BIT_CYC = 16 * CLK_DIV;
  localparam int TCW     = $clog2(BIT_CYC);
  localparam int DW      = $clog2(CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

  // ---------------- transmitter ----------------
  state_t                 r_tx_state, w_tx_next;
  logic [TCW-1:0]         r_tx_cnt;
  logic [3:0]             r_tx_idx;
  logic [DATA_BITS-1:0]   r_tx_shift;
  logic                   r_tx_par;
  logic                   w_tx_bit_end, w_tx_d, w_busy_d, w_tx_par_in;

  assign w_tx_bit_end = (r_tx_cnt == TCW'(BIT_CYC - 1));
  assign w_tx_par_in  = (PARITY == 1) ? ~(^din) : (^din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= S_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      S_IDLE:  if (wr_en) w_tx_next = S_START;
      S_START: if (w_tx_bit_end) w_tx_next = S_DATA;
      S_DATA:  if (w_tx_bit_end && r_tx_idx == 4'(DATA_BITS - 1))
                 w_tx_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (w_tx_bit_end) w_tx_next = S_STOP;
      S_STOP:  if (w_tx_bit_end && r_tx_idx == 4'(STOP_BITS - 1)) w_tx_next = S_IDLE;
      default: w_tx_next = S_IDLE;
    endcase
  end

  // Line level is computed for the coming state so tx itself can be a flop.
  always_comb begin
    w_busy_d = (w_tx_next != S_IDLE);
    w_tx_d   = 1'b1;
    case (w_tx_next)
      S_START: w_tx_d = 1'b0;
      S_DATA:  w_tx_d = (r_tx_state == S_DATA && w_tx_bit_end) ? r_tx_shift[1] : r_tx_shift[0];
      S_PAR:   w_tx_d = r_tx_par;
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      tx      <= w_tx_d;
      tx_busy <= w_busy_d;
      if (r_tx_state == S_IDLE || w_tx_bit_end) r_tx_cnt <= '0;
      else                                      r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_tx_next != r_tx_state) r_tx_idx <= '0;
      else if (w_tx_bit_end)       r_tx_idx <= r_tx_idx + 1'b1;
      if (r_tx_state == S_IDLE && wr_en) begin
        r_tx_shift <= din;
        r_tx_par   <= w_tx_par_in;
      end else if (r_tx_state == S_DATA && w_tx_bit_end) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
    end
  end

  // ---------------- receiver ----------------
  logic                 r_rx_s1, r_rx_s2, r_rx_s3;
  logic [DW-1:0]        r_div;
  state_t               r_rx_state, w_rx_next;
  logic [3:0]           r_rx_cnt, r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 w_tick, w_rx_mid, w_rx_fall, w_rx_done, w_par_err;

  assign w_tick    = (r_div == DW'(CLK_DIV - 1));
  assign w_rx_mid  = w_tick && (r_rx_cnt == 4'd15);
  assign w_rx_fall = r_rx_s3 && !r_rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
      r_div   <= '0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= S_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
      S_START: if (w_tick && r_rx_cnt == 4'd7) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_mid && r_rx_idx == 4'(DATA_BITS - 1))
                 w_rx_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (w_rx_mid) w_rx_next = S_STOP;
      S_STOP:  if (w_rx_mid) w_rx_next = r_rx_s2 ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s2) w_rx_next = S_IDLE;
      default: w_rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_done = (r_rx_state == S_STOP) && w_rx_mid;
    w_par_err = 1'b0;
    if (PARITY == 1)      w_par_err = ~((^r_rx_shift) ^ r_rx_par);
    else if (PARITY == 2) w_par_err = (^r_rx_shift) ^ r_rx_par;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      dout       <= '0;
      rdy        <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_rx_next != r_rx_state || r_rx_state == S_IDLE) r_rx_cnt <= '0;
      else if (w_tick)                                      r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_rx_next != r_rx_state)                 r_rx_idx <= '0;
      else if (r_rx_state == S_DATA && w_rx_mid)   r_rx_idx <= r_rx_idx + 1'b1;
      if (r_rx_state == S_DATA && w_rx_mid) r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
      if (r_rx_state == S_PAR && w_rx_mid)  r_rx_par   <= r_rx_s2;
      // A completing frame wins over a same-cycle clear.
      if (w_rx_done) begin
        dout       <= r_rx_shift;
        rdy        <= 1'b1;
        frame_err  <= !r_rx_s2;
        parity_err <= w_par_err;
        overrun    <= rdy_clr ? 1'b0 : (overrun | rdy);
      end else if (rdy_clr) begin
        rdy        <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Scoreboard bench for uart_param: loopback (even parity), driven RX (odd parity), 5-bit/2-stop loopback.
module tb_uart_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst0_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // u0: 8 bits, even parity, 1 stop, loopback
  logic [7:0] din0, dout0;
  logic wr0, tx0, busy0, rdy0, clr0, fe0, pe0, ov0;
  // u1: 8 bits, odd parity, 1 stop, bench-driven rx
  logic [7:0] din1, dout1;
  logic wr1, tx1, busy1, rx1, rdy1, clr1, fe1, pe1, ov1;
  // u2: 5 bits, no parity, 2 stop, loopback
  logic [4:0] din2, dout2;
  logic wr2, tx2, busy2, rdy2, clr2, fe2, pe2, ov2;

  uart_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLK_DIV(4)) u0 (
    .clk(clk), .rst_n(rst0_n), .din(din0), .wr_en(wr0), .tx(tx0), .tx_busy(busy0),
    .rx(tx0), .dout(dout0), .rdy(rdy0), .rdy_clr(clr0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLK_DIV(4)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .wr_en(wr1), .tx(tx1), .tx_busy(busy1),
    .rx(rx1), .dout(dout1), .rdy(rdy1), .rdy_clr(clr1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  uart_param #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .CLK_DIV(4)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .wr_en(wr2), .tx(tx2), .tx_busy(busy2),
    .rx(tx2), .dout(dout2), .rdy(rdy2), .rdy_clr(clr2),
    .frame_err(fe2), .parity_err(pe2), .overrun(ov2));

  logic [11:0] q0[$], q1[$], q2[$];

  function automatic logic [11:0] pack(input logic fe, input logic pe, input logic ov,
                                       input logic [8:0] d);
    return {fe, pe, ov, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitors: a new character is presented when rdy rises, or when the
  // received word/flags change while rdy stays high.
  logic [11:0] prev0, prev1, prev2, cur0, cur1, cur2;
  logic        prdy0 = 1'b0, prdy1 = 1'b0, prdy2 = 1'b0;

  always @(negedge clk) begin
    cur0 = pack(fe0, pe0, ov0, {1'b0, dout0});
    if (rdy0 && (!prdy0 || cur0 != prev0)) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u0 unexpected char: got %0h expected none", cur0);
      end else chk("u0 char", {20'd0, cur0}, {20'd0, q0.pop_front()});
    end
    prdy0 = rdy0; prev0 = cur0;
  end

  always @(negedge clk) begin
    cur1 = pack(fe1, pe1, ov1, {1'b0, dout1});
    if (rdy1 && (!prdy1 || cur1 != prev1)) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u1 unexpected char: got %0h expected none", cur1);
      end else chk("u1 char", {20'd0, cur1}, {20'd0, q1.pop_front()});
    end
    prdy1 = rdy1; prev1 = cur1;
  end

  always @(negedge clk) begin
    cur2 = pack(fe2, pe2, ov2, {4'd0, dout2});
    if (rdy2 && (!prdy2 || cur2 != prev2)) begin
      if (q2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u2 unexpected char: got %0h expected none", cur2);
      end else chk("u2 char", {20'd0, cur2}, {20'd0, q2.pop_front()});
    end
    prdy2 = rdy2; prev2 = cur2;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit period is 64 cycles at CLK_DIV=4.
  task automatic send_rx1(input logic [7:0] d, input logic p, input logic stop_lvl,
                          input int stop_len);
    logic [7:0] dv;
    dv = d;
    rx1 = 1'b0; wait_cyc(64);
    for (int i = 0; i < 8; i++) begin
      rx1 = dv[i]; wait_cyc(64);
    end
    rx1 = p;        wait_cyc(64);
    rx1 = stop_lvl; wait_cyc(64 * stop_len);
    rx1 = 1'b1;     wait_cyc(64);
  endtask

  task automatic pulse_clr1();
    @(negedge clk); clr1 = 1'b1;
    @(negedge clk); clr1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   busy_cnt;
    logic par_bit, start_bit, stop_bit, hit;
    rst_n = 1'b0; rst0_n = 1'b0;
    din0 = '0; wr0 = 1'b0; clr0 = 1'b0;
    din1 = '0; wr1 = 1'b0; clr1 = 1'b0; rx1 = 1'b1;
    din2 = '0; wr2 = 1'b0; clr2 = 1'b0;
    wait_cyc(3);
    chk("reset tx",      {31'd0, tx0},   32'd1);
    chk("reset tx_busy", {31'd0, busy0}, 32'd0);
    chk("reset dout",    {24'd0, dout0}, 32'd0);
    chk("reset rdy",     {31'd0, rdy0},  32'd0);
    chk("reset flags",   {29'd0, fe0, pe0, ov0}, 32'd0);
    rst_n = 1'b1; rst0_n = 1'b1;
    wait_cyc(10);

    // Loopback 0xA5, even parity: 11 bits * 64 = 704 busy cycles, parity bit 0.
    din0 = 8'hA5; wr0 = 1'b1; q0.push_back(pack(0, 0, 0, 9'h0A5));
    @(posedge clk); #1 wr0 = 1'b0;
    busy_cnt = 0; par_bit = 1'bx; start_bit = 1'bx; stop_bit = 1'bx;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
      if (i == 32)  start_bit = tx0;
      if (i == 609) par_bit   = tx0;
      if (i == 673) stop_bit  = tx0;
    end
    chk("u0 busy cycles", busy_cnt, 32'd704);
    chk("u0 start bit",   {31'd0, start_bit}, 32'd0);
    chk("u0 parity bit",  {31'd0, par_bit},   32'd0);
    chk("u0 stop bit",    {31'd0, stop_bit},  32'd1);
    chk("u0 rdy",         {31'd0, rdy0},      32'd1);
    chk("u0 drained",     q0.size(),          32'd0);

    // Reset during data bit 3 (0x35 bit 3 = 0) with rdy still set.
    din0 = 8'h35; wr0 = 1'b1;
    @(posedge clk); #1 wr0 = 1'b0;
    for (int i = 0; i <= 290; i++) @(negedge clk);
    chk("pre-reset tx",   {31'd0, tx0},   32'd0);
    chk("pre-reset busy", {31'd0, busy0}, 32'd1);
    rst0_n = 1'b0;
    #1;
    chk("async rst tx",   {31'd0, tx0},   32'd1);
    chk("async rst busy", {31'd0, busy0}, 32'd0);
    chk("async rst rdy",  {31'd0, rdy0},  32'd0);
    chk("async rst dout", {24'd0, dout0}, 32'd0);
    wait_cyc(5); rst0_n = 1'b1; wait_cyc(100);
    din0 = 8'hC3; wr0 = 1'b1; q0.push_back(pack(0, 0, 0, 9'h0C3));
    @(posedge clk); #1 wr0 = 1'b0;
    wait_cyc(800);
    chk("u0 post-reset drained", q0.size(), 32'd0);

    // Odd parity: 0x0F has four ones, so parity bit 0 is an error, 1 is clean.
    q1.push_back(pack(0, 1, 0, 9'h00F));
    send_rx1(8'h0F, 1'b0, 1'b1, 1);
    chk("u1 parity_err", {31'd0, pe1}, 32'd1);
    pulse_clr1();
    chk("u1 clr rdy",        {31'd0, rdy1}, 32'd0);
    chk("u1 clr parity_err", {31'd0, pe1},  32'd0);
    q1.push_back(pack(0, 0, 0, 9'h00F));
    send_rx1(8'h0F, 1'b1, 1'b1, 1);
    pulse_clr1();

    // Stop bit low for 3 bit times: frame error, then clean 0x55 after break.
    q1.push_back(pack(1, 0, 0, 9'h0F0));
    send_rx1(8'hF0, 1'b1, 1'b0, 3);
    chk("u1 frame_err", {31'd0, fe1}, 32'd1);
    pulse_clr1();
    chk("u1 clr frame_err", {31'd0, fe1}, 32'd0);
    q1.push_back(pack(0, 0, 0, 9'h055));
    send_rx1(8'h55, 1'b1, 1'b1, 1);
    chk("u1 after break dout", {24'd0, dout1}, 32'h55);
    pulse_clr1();

    // 4-cycle glitch must not produce a character.
    rx1 = 1'b0; wait_cyc(4); rx1 = 1'b1;
    wait_cyc(800);
    chk("u1 glitch rdy", {31'd0, rdy1}, 32'd0);

    // Overrun: 0x11 then 0x22 without clearing.
    q1.push_back(pack(0, 0, 0, 9'h011));
    send_rx1(8'h11, 1'b1, 1'b1, 1);
    q1.push_back(pack(0, 0, 1, 9'h022));
    send_rx1(8'h22, 1'b1, 1'b1, 1);
    chk("u1 overrun",      {31'd0, ov1},   32'd1);
    chk("u1 overrun dout", {24'd0, dout1}, 32'h22);

    // Third frame completes on the same edge as rdy_clr.
    q1.push_back(pack(0, 0, 0, 9'h033));
    hit = 1'b0;
    fork
      send_rx1(8'h33, 1'b1, 1'b1, 1);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (u1.w_rx_done) begin
            clr1 = 1'b1;
            @(negedge clk);
            clr1 = 1'b0;
            hit = 1'b1;
            break;
          end
        end
      end
    join
    chk("u1 clr collision seen", {31'd0, hit},  32'd1);
    chk("u1 collision rdy",      {31'd0, rdy1}, 32'd1);
    chk("u1 collision overrun",  {31'd0, ov1},  32'd0);
    chk("u1 drained",            q1.size(),     32'd0);

    // 5 data bits, 2 stop bits, no parity: 8 bits * 64 = 512 busy cycles.
    din2 = 5'h1B; wr2 = 1'b1; q2.push_back(pack(0, 0, 0, 9'h01B));
    @(posedge clk); #1 wr2 = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 200) begin wr2 = 1'b1; din2 = 5'h04; end
      if (i == 201) wr2 = 1'b0;
      if (busy2) busy_cnt++;
    end
    chk("u2 busy cycles", busy_cnt, 32'd512);
    wait_cyc(700);
    chk("u2 dout",    {27'd0, dout2}, 32'h1B);
    chk("u2 drained", q2.size(),      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
